register_bank: RTL and testbench



---
 rtl/register_bank.sv | 112 +++++++++++
 tb/tb_register_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: 32-entry, 2-read/1-write RV32I integer register file.
// Entry 0 reads as constant zero; reads are combinational, writes clocked.

// One-hot decoder: decoded[i] = enable && (encoded == i).
module register_bank_decoder #(
   parameter int unsigned W = 5
) (
   input  logic              enable,
   input  logic [W-1:0]      encoded,
   output logic [(2**W)-1:0] decoded
);

   localparam int unsigned NUM_OUT = 2 ** W;

   // Compare the encoded value against every output index.
   always_comb begin
      decoded = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         decoded[i] = enable && (encoded == W'(i));
      end
   end

endmodule

// Enable-gated register with synchronous active-high reset; rst beats ena.
module register_bank_reg #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] q_d;
   logic [N-1:0] q_q;

   // Load new data only when enabled, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (ena) begin
         q_d = d;
      end
   end

   // State register; reset wins over any pending load.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// Top level: decoder, 31 storage registers, two independent read muxes.
module register_bank #(
   parameter int unsigned REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wrEna,
   input  logic [4:0]           wrAddr,
   input  logic [REG_WIDTH-1:0] wrData,
   input  logic [4:0]           rdAddr0,
   input  logic [4:0]           rdAddr1,
   output logic [REG_WIDTH-1:0] rdData0,
   output logic [REG_WIDTH-1:0] rdData1
);

   localparam int unsigned ADDR_W      = 5;
   localparam int unsigned NUM_ENTRIES = 2 ** ADDR_W;

   logic [NUM_ENTRIES-1:0] wr_dec;
   logic [REG_WIDTH-1:0]   entry [NUM_ENTRIES];
   logic                   unused_dec0;

   // Write-address decode into per-entry load enables.
   register_bank_decoder #(
      .W (ADDR_W)
   ) u_dec (
      .enable  (wrEna),
      .encoded (wrAddr),
      .decoded (wr_dec)
   );

   // x0 has no storage, so its enable is intentionally dropped.
   assign unused_dec0 = wr_dec[0];
   assign entry[0]    = '0;

   // Entries 1..31 each get their own enable-gated register.
   for (genvar g = 1; g < NUM_ENTRIES; g++) begin : g_entry
      register_bank_reg #(
         .N (REG_WIDTH)
      ) u_reg (
         .clk (clk),
         .rst (rst),
         .ena (wr_dec[g]),
         .d   (wrData),
         .q   (entry[g])
      );
   end

   // Combinational read ports, no write bypass.
   assign rdData0 = entry[rdAddr0];
   assign rdData1 = entry[rdAddr1];

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank and its decoder.
`timescale 1ns/1ps
module tb_register_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEna;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;
   logic [4:0]  rdAddr0;
   logic [4:0]  rdAddr1;
   logic [31:0] rdData0;
   logic [31:0] rdData1;

   logic        dec_en;
   logic [4:0]  dec_enc;
   logic [31:0] dec_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   register_bank #(.REG_WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .wrEna   (wrEna),
      .wrAddr  (wrAddr),
      .wrData  (wrData),
      .rdAddr0 (rdAddr0),
      .rdAddr1 (rdAddr1),
      .rdData0 (rdData0),
      .rdData1 (rdData1)
   );

   register_bank_decoder #(.W(5)) u_dec (
      .enable  (dec_en),
      .encoded (dec_enc),
      .decoded (dec_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      wrEna  = 1'b1;
      wrAddr = a;
      wrData = d;
      tick();
      wrEna  = 1'b0;
   endtask

   task automatic read_both(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
      rdAddr0 = a0;
      rdAddr1 = a1;
      #1;
      check({tag, "_p0"}, rdData0, e0);
      check({tag, "_p1"}, rdData1, e1);
   endtask

   initial begin
      rst = 1'b1; wrEna = 1'b0; wrAddr = '0; wrData = '0;
      rdAddr0 = '0; rdAddr1 = '0; dec_en = 1'b0; dec_enc = '0;
      #2;
      tick();
      rst = 1'b0;

      // Reset state: every entry reads zero.
      for (int i = 0; i < 32; i++) begin
         read_both($sformatf("init_x%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
      end

      // Reset clears a written entry.
      write_reg(5'd5, 32'hDEADBEEF);
      read_both("x5_written", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      read_both("x5_after_rst", 5'd5, 5'd5, 32'h0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         read_both($sformatf("rst_x%0d", i), 5'(i), 5'(i), 32'h0, 32'h0);
      end

      // Write then dual read, then swap.
      write_reg(5'd7, 32'h12345678);
      write_reg(5'd31, 32'hCAFEF00D);
      read_both("dual", 5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D);
      read_both("dual_swap", 5'd31, 5'd7, 32'hCAFEF00D, 32'h12345678);
      read_both("same_entry", 5'd7, 5'd7, 32'h12345678, 32'h12345678);

      // x0 is immutable and a write to it touches nothing else.
      write_reg(5'd0, 32'hFFFFFFFF);
      read_both("x0_wr", 5'd0, 5'd0, 32'h0, 32'h0);
      read_both("x0_side", 5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D);
      read_both("x0_side2", 5'd1, 5'd5, 32'h0, 32'h0);

      // Enable gating: no write with wrEna low.
      wrEna = 1'b0; wrAddr = 5'd9; wrData = 32'hAAAA5555;
      repeat (3) tick();
      read_both("gate_x9", 5'd9, 5'd7, 32'h0, 32'h12345678);

      // Decoder disabled gives all-zero.
      dec_en = 1'b0;
      foreach (dec_enc[k]) begin
         dec_enc = 5'(1 << k);
         #1;
         check($sformatf("dec_off_%0d", k), dec_out, 32'h0);
      end

      // Read during write: old value before the edge, new after.
      write_reg(5'd4, 32'h11);
      rdAddr0 = 5'd4;
      wrEna = 1'b1; wrAddr = 5'd4; wrData = 32'h22;
      #1;
      check("rdw_before", rdData0, 32'h11);
      tick();
      wrEna = 1'b0;
      check("rdw_after", rdData0, 32'h22);

      // Write then reset-with-write at the same edge.
      write_reg(5'd3, 32'h99);
      read_both("x3_pre", 5'd3, 5'd4, 32'h99, 32'h22);
      rst = 1'b1; wrEna = 1'b1; wrAddr = 5'd3; wrData = 32'h55;
      tick();
      rst = 1'b0; wrEna = 1'b0;
      read_both("rst_beats_wr", 5'd3, 5'd4, 32'h0, 32'h0);
      read_both("rst_beats_wr2", 5'd7, 5'd31, 32'h0, 32'h0);

      // Decoder sweep with enable high.
      dec_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         dec_enc = 5'(i);
         #1;
         check($sformatf("dec_sweep_%0d", i), dec_out, 32'h1 << i);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
